input_sequencer: RTL and testbench

INPUT_SEQUENCER -- requirements
Module: input_sequencer

---
 rtl/input_sequencer.sv | 136 +++++++++++++
 tb/tb_input_sequencer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_sequencer.sv
// Four-button input sequencer: press detect, hold auto-repeat, round-robin
// arbitration of pending requests into a two-entry command FIFO.
module input_sequencer #(
    parameter int HOLD_DELAY    = 24,
    parameter int REPEAT_PERIOD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] button,
    output logic       cmd_valid,
    output logic [1:0] cmd_id,
    output logic       cmd_repeat,
    input  logic       cmd_ready,
    output logic [7:0] drop_cnt
);

    // Reload value keeps later repeats REPEAT_PERIOD apart (assumes REPEAT_PERIOD <= HOLD_DELAY).
    localparam logic [7:0] REPEAT_AT = 8'(HOLD_DELAY - 1);
    localparam logic [7:0] RELOAD_AT = 8'(HOLD_DELAY - REPEAT_PERIOD);

    logic [3:0] prev;
    logic [3:0] pending;
    logic [3:0] rep;
    logic       trk_active;
    logic [1:0] owner;
    logic [7:0] hold_cnt;
    logic [1:0] rr_ptr;
    logic       rd_ptr;
    logic [1:0] fifo_cnt;
    logic [2:0] fifo_mem [2];

    logic [3:0] press;
    logic [3:0] repeat_ev;
    logic [3:0] event_v;
    logic [1:0] press_id;
    logic       owner_held;
    logic       pop;
    logic       can_grant;
    logic       grant;
    logic [1:0] grant_id;
    logic [2:0] drop_inc;
    logic       wr_ptr;

    function automatic logic [7:0] sat_add(input logic [7:0] a, input logic [2:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {6'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    always_comb begin
        press      = button & ~prev;
        owner_held = trk_active && button[owner];
        repeat_ev  = 4'd0;
        if (owner_held && hold_cnt == REPEAT_AT)
            repeat_ev[owner] = 1'b1;
        event_v = press | repeat_ev;

        press_id = 2'd0;
        for (int i = 3; i >= 0; i--)
            if (press[i]) press_id = 2'(i);

        pop       = (fifo_cnt != 2'd0) && cmd_ready;
        can_grant = (fifo_cnt < 2'd2) || pop;

        // Scan downward so the pending id nearest to rr_ptr is the last one written.
        grant    = 1'b0;
        grant_id = rr_ptr;
        for (int j = 3; j >= 0; j--) begin
            if (can_grant && pending[2'(rr_ptr + 2'(j))]) begin
                grant    = 1'b1;
                grant_id = 2'(rr_ptr + 2'(j));
            end
        end

        drop_inc = 3'd0;
        for (int i = 0; i < 4; i++)
            if (event_v[i] && pending[i] && !(grant && grant_id == 2'(i)))
                drop_inc = drop_inc + 3'd1;
    end

    assign wr_ptr = rd_ptr ^ fifo_cnt[0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev       <= 4'd0;
            pending    <= 4'd0;
            rep        <= 4'd0;
            trk_active <= 1'b0;
            owner      <= 2'd0;
            hold_cnt   <= 8'd0;
            rr_ptr     <= 2'd0;
            rd_ptr     <= 1'b0;
            fifo_cnt   <= 2'd0;
            drop_cnt   <= 8'd0;
        end else begin
            prev <= button;

            if (|press) begin
                trk_active <= 1'b1;
                owner      <= press_id;
                hold_cnt   <= 8'd0;
            end else if (owner_held) begin
                hold_cnt <= (hold_cnt == REPEAT_AT) ? RELOAD_AT : hold_cnt + 8'd1;
            end else begin
                trk_active <= 1'b0;
            end

            // A fresh event on the granted id keeps it pending with the new kind.
            for (int i = 0; i < 4; i++) begin
                if (event_v[i]) begin
                    pending[i] <= 1'b1;
                    rep[i]     <= ~press[i];
                end else if (grant && grant_id == 2'(i)) begin
                    pending[i] <= 1'b0;
                end
            end

            if (grant)
                rr_ptr <= grant_id + 2'd1;
            if (pop)
                rd_ptr <= ~rd_ptr;
            fifo_cnt <= fifo_cnt + {1'b0, grant} - {1'b0, pop};
            drop_cnt <= sat_add(drop_cnt, drop_inc);
        end
    end

    always_ff @(posedge clk) begin
        if (grant)
            fifo_mem[wr_ptr] <= {grant_id, rep[grant_id]};
    end

    assign cmd_valid  = (fifo_cnt != 2'd0);
    assign cmd_id     = cmd_valid ? fifo_mem[rd_ptr][2:1] : 2'd0;
    assign cmd_repeat = cmd_valid && fifo_mem[rd_ptr][0];

endmodule

// File: tb/tb_input_sequencer.sv
// Bench for input_sequencer: directed scenarios plus randomized buttons/ready,
// all checked against a hold-age based reference model with a command queue.
module tb_input_sequencer;

    localparam int HOLD = 24;
    localparam int PER  = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] button = 4'd0;
    logic       cmd_ready = 1'b0;
    logic       cmd_valid;
    logic [1:0] cmd_id;
    logic       cmd_repeat;
    logic [7:0] drop_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit m_prev[4];
    bit m_pend[4];
    bit m_rep[4];
    bit m_act;
    int m_owner;
    int m_age;
    int m_rr;
    int m_drop;
    int m_fifo[$];
    int got[$];

    always #5 clk = ~clk;

    input_sequencer #(.HOLD_DELAY(HOLD), .REPEAT_PERIOD(PER)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .button(button),
        .cmd_valid(cmd_valid),
        .cmd_id(cmd_id),
        .cmd_repeat(cmd_repeat),
        .cmd_ready(cmd_ready),
        .drop_cnt(drop_cnt)
    );

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_prev[i] = 0;
            m_pend[i] = 0;
            m_rep[i]  = 0;
        end
        m_act = 0;
        m_owner = 0;
        m_age = 0;
        m_rr = 0;
        m_drop = 0;
        m_fifo.delete();
    endtask

    // One rising edge of the reference behaviour, using the inputs held across it.
    task automatic model_step();
        bit pop;
        bit press[4];
        int rep_id;
        int p_id;
        int gid;
        bit ev;
        pop = (m_fifo.size() > 0) && cmd_ready;

        rep_id = -1;
        if (m_act && button[m_owner]) begin
            m_age++;
            if (m_age >= HOLD && (m_age - HOLD) % PER == 0) rep_id = m_owner;
        end else begin
            m_act = 0;
        end

        p_id = -1;
        for (int i = 0; i < 4; i++) begin
            press[i] = button[i] && !m_prev[i];
            if (press[i] && p_id < 0) p_id = i;
        end
        if (p_id >= 0) begin
            m_act = 1;
            m_owner = p_id;
            m_age = 0;
        end

        gid = -1;
        if (m_fifo.size() < 2 || pop)
            for (int j = 0; j < 4; j++)
                if (gid < 0 && m_pend[(m_rr + j) % 4]) gid = (m_rr + j) % 4;

        for (int i = 0; i < 4; i++) begin
            ev = press[i] || (rep_id == i);
            if (ev && m_pend[i] && gid != i && m_drop < 255) m_drop++;
        end

        if (pop) void'(m_fifo.pop_front());
        if (gid >= 0) begin
            m_fifo.push_back(gid * 2 + int'(m_rep[gid]));
            m_rr = (gid + 1) % 4;
        end

        for (int i = 0; i < 4; i++) begin
            ev = press[i] || (rep_id == i);
            if (ev) begin
                m_pend[i] = 1;
                m_rep[i]  = !press[i];
            end else if (gid == i) begin
                m_pend[i] = 0;
            end
            m_prev[i] = button[i];
        end
    endtask

    task automatic compare_outputs();
        check_val("cmd_valid", int'(cmd_valid), int'(m_fifo.size() > 0));
        if (m_fifo.size() > 0) begin
            check_val("cmd_id", int'(cmd_id), m_fifo[0] / 2);
            check_val("cmd_repeat", int'(cmd_repeat), m_fifo[0] % 2);
        end
        check_val("drop_cnt", int'(drop_cnt), m_drop);
    endtask

    // Called at a falling edge with inputs already set for the coming rising edge.
    task automatic cycle();
        if (cmd_valid && cmd_ready) got.push_back(int'(cmd_id) * 2 + int'(cmd_repeat));
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_outputs();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check_val("rst_cmd_valid", int'(cmd_valid), 0);
        check_val("rst_cmd_id", int'(cmd_id), 0);
        check_val("rst_cmd_repeat", int'(cmd_repeat), 0);
        check_val("rst_drop_cnt", int'(drop_cnt), 0);
        model_reset();
        got.delete();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic check_log(input string tag, input int n, input int e0, input int e1,
                             input int e2, input int e3);
        int e;
        check_val({tag, "_len"}, got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            e = (i == 0) ? e0 : (i == 1) ? e1 : (i == 2) ? e2 : e3;
            check_val(tag, got[i], e);
        end
    endtask

    initial begin
        model_reset();
        @(negedge clk);

        // Single-cycle tap of button 2
        do_reset();
        cmd_ready = 1'b1;
        button = 4'b0100;
        cycle();
        check_val("tap_lat_edge1", int'(cmd_valid), 0);
        button = 4'b0000;
        cycle();
        check_val("tap_valid", int'(cmd_valid), 1);
        check_val("tap_id", int'(cmd_id), 2);
        check_val("tap_repeat", int'(cmd_repeat), 0);
        cycle();
        check_val("tap_one_cycle", int'(cmd_valid), 0);
        run(3);

        // Hold button 1 for 45 cycles, with an unsampled release/repress inside
        do_reset();
        cmd_ready = 1'b1;
        for (int c = 0; c < 45; c++) begin
            if (c == 30) begin
                button = 4'b0000;
                #1;
            end
            button = 4'b0010;
            cycle();
        end
        button = 4'b0000;
        run(15);
        check_log("hold_log", 4, 2, 3, 3, 3);

        // All four pressed together while the consumer stalls
        do_reset();
        cmd_ready = 1'b0;
        button = 4'b1111;
        cycle();
        button = 4'b0000;
        run(4);
        check_val("rr_full_head", int'(cmd_id), 0);
        cmd_ready = 1'b1;
        run(8);
        check_log("rr_order", 4, 0, 2, 4, 6);

        // Repeated presses of button 3 against a full FIFO
        do_reset();
        cmd_ready = 1'b0;
        button = 4'b0011;
        cycle();
        button = 4'b0000;
        run(2);
        for (int t = 0; t < 3; t++) begin
            button = 4'b1000;
            cycle();
            button = 4'b0000;
            cycle();
        end
        check_val("merge_drop", int'(drop_cnt), 2);
        cmd_ready = 1'b1;
        run(6);
        check_log("merge_log", 3, 0, 2, 6, 0);

        // Same-cycle pop and push at full FIFO
        do_reset();
        cmd_ready = 1'b0;
        button = 4'b0111;
        cycle();
        button = 4'b0000;
        run(2);
        cmd_ready = 1'b1;
        cycle();
        check_val("pp_valid", int'(cmd_valid), 1);
        check_val("pp_head", int'(cmd_id), 1);
        cmd_ready = 1'b0;
        cycle();
        check_val("pp_stable", int'(cmd_id), 1);
        cmd_ready = 1'b1;
        run(4);
        check_log("pp_log", 3, 0, 2, 4, 0);

        // Reset while commands are queued and button 0 is held
        do_reset();
        cmd_ready = 1'b0;
        button = 4'b0011;
        cycle();
        button = 4'b0001;
        run(3);
        do_reset();
        cycle();
        cycle();
        check_val("rst_hold_valid", int'(cmd_valid), 1);
        check_val("rst_hold_id", int'(cmd_id), 0);
        check_val("rst_hold_rep", int'(cmd_repeat), 0);
        check_val("rst_hold_drop", int'(drop_cnt), 0);
        cmd_ready = 1'b1;
        button = 4'b0000;
        run(5);
        check_log("rst_hold_log", 1, 0, 0, 0, 0);

        // Drop counter saturation
        do_reset();
        cmd_ready = 1'b0;
        button = 4'b0011;
        cycle();
        button = 4'b0000;
        run(2);
        for (int t = 0; t < 260; t++) begin
            button = 4'b1000;
            cycle();
            button = 4'b0000;
            cycle();
        end
        check_val("drop_saturate", int'(drop_cnt), 255);

        // Randomized buttons and back-pressure
        do_reset();
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, (c % 1000 < 500) ? 6 : 30) == 0) button[i] = ~button[i];
            cmd_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 999) == 0) do_reset();
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
